// File: rtl/pattern_arbiter.sv
// pattern_arbiter: owns the shared seven-segment display and picks which of three
// pattern generators drives it. Buttons are synchronized and debounced. Simultaneous
// presses resolve by fixed priority. A source switch blanks the display for
// BLANK_CYCLES. After IDLE_STEPS step_en pulses without a press, the block
// auto-rotates through the patterns.
//
// Ports:
//   CLK              system clock
//   RST              synchronous, active-high reset
//   btn1/btn2/btn3   raw asynchronous buttons selecting pattern 0/1/2
//   step_en          one-cycle strobe at the selected pattern speed
//   seg_a/b/c        active-low segment buses of patterns 0/1/2
//   an_a/b/c         active-low anode buses of patterns 0/1/2
//   seg, an          registered display outputs
//   active           index of the displayed pattern (0..2)
//   auto_mode        high while auto-rotating
module pattern_arbiter #(
   parameter int unsigned DB_CYCLES    = 500000,
   parameter int unsigned BLANK_CYCLES = 1000000,
   parameter int unsigned IDLE_STEPS   = 64,
   parameter int unsigned AUTO_STEPS   = 16
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       btn1,
   input  logic       btn2,
   input  logic       btn3,
   input  logic       step_en,
   input  logic [7:0] seg_a,
   input  logic [7:0] seg_b,
   input  logic [7:0] seg_c,
   input  logic [3:0] an_a,
   input  logic [3:0] an_b,
   input  logic [3:0] an_c,
   output logic [7:0] seg,
   output logic [3:0] an,
   output logic [1:0] active,
   output logic       auto_mode
);

   localparam int unsigned DbW    = $clog2(DB_CYCLES + 1);
   localparam int unsigned BlankW = $clog2(BLANK_CYCLES + 1);
   localparam int unsigned IdleW  = $clog2(IDLE_STEPS + 1);
   localparam int unsigned RotW   = $clog2(AUTO_STEPS + 1);

   // Counter values on the cycle before each counter reaches its limit.
   localparam logic [DbW-1:0]    DbLast    = DbW'(DB_CYCLES - 1);
   localparam logic [BlankW-1:0] BlankLast = BlankW'(BLANK_CYCLES - 1);
   localparam logic [IdleW-1:0]  IdleLast  = IdleW'(IDLE_STEPS - 1);
   localparam logic [IdleW-1:0]  IdleSat   = IdleW'(IDLE_STEPS);
   localparam logic [RotW-1:0]   RotLast   = RotW'(AUTO_STEPS - 1);

   typedef enum logic [1:0] {
      StManual,
      StBlank,
      StAuto
   } state_e;

   // ------------------------------------------------------------------
   // Button synchronizers and debouncers
   // ------------------------------------------------------------------
   logic [2:0]          btn_raw;
   logic [2:0]          meta_q, sync_q;
   logic [2:0]          db_q, db_d, db_prev_q;
   logic [2:0][DbW-1:0] db_cnt_q, db_cnt_d;
   logic [2:0]          press;

   assign btn_raw = {btn3, btn2, btn1};

   // A level change is accepted once the synced level has disagreed with the
   // debounced level for DB_CYCLES consecutive cycles.
   always_comb begin
      db_d     = db_q;
      db_cnt_d = '0;
      for (int i = 0; i < 3; i++) begin
         if (sync_q[i] != db_q[i]) begin
            if (db_cnt_q[i] == DbLast) begin
               db_d[i] = sync_q[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
         end
      end
   end

   // Only the rising edge of the debounced level counts; releases are silent.
   assign press = db_q & ~db_prev_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         meta_q    <= '0;
         sync_q    <= '0;
         db_q      <= '0;
         db_prev_q <= '0;
         db_cnt_q  <= '0;
      end else begin
         meta_q    <= btn_raw;
         sync_q    <= meta_q;
         db_q      <= db_d;
         db_prev_q <= db_q;
         db_cnt_q  <= db_cnt_d;
      end
   end

   // ------------------------------------------------------------------
   // Priority: btn1 > btn2 > btn3
   // ------------------------------------------------------------------
   logic       any_press;
   logic [1:0] press_tgt;

   assign any_press = |press;

   always_comb begin
      if (press[0]) begin
         press_tgt = 2'd0;
      end else if (press[1]) begin
         press_tgt = 2'd1;
      end else begin
         press_tgt = 2'd2;
      end
   end

   // ------------------------------------------------------------------
   // Sequencer FSM
   // ------------------------------------------------------------------
   state_e            state_q, state_d;
   logic [1:0]        active_q, active_d;
   logic [1:0]        target_q, target_d;
   logic [BlankW-1:0] blank_q, blank_d;
   logic [IdleW-1:0]  idle_q, idle_d;
   logic [RotW-1:0]   rot_q, rot_d;

   always_comb begin
      state_d  = state_q;
      active_d = active_q;
      target_d = target_q;
      blank_d  = blank_q;
      idle_d   = idle_q;
      rot_d    = rot_q;

      unique case (state_q)
         StManual: begin
            // A press takes precedence over a same-cycle step_en.
            if (any_press) begin
               if (press_tgt != active_q) begin
                  state_d  = StBlank;
                  target_d = press_tgt;
                  blank_d  = '0;
               end else begin
                  idle_d = '0;
               end
            end else if (step_en) begin
               if (idle_q == IdleLast) begin
                  state_d = StAuto;
                  idle_d  = IdleSat;
                  rot_d   = '0;
               end else begin
                  idle_d = idle_q + 1'b1;
               end
            end
         end

         StBlank: begin
            if (any_press) begin
               target_d = press_tgt;
               blank_d  = '0;
            end else if (blank_q == BlankLast) begin
               state_d  = StManual;
               active_d = target_q;
               blank_d  = '0;
               idle_d   = '0;
            end else begin
               blank_d = blank_q + 1'b1;
            end
         end

         StAuto: begin
            if (any_press) begin
               if (press_tgt != active_q) begin
                  state_d  = StBlank;
                  target_d = press_tgt;
                  blank_d  = '0;
               end else begin
                  state_d = StManual;
                  idle_d  = '0;
               end
            end else if (step_en) begin
               if (rot_q == RotLast) begin
                  rot_d    = '0;
                  active_d = (active_q == 2'd2) ? 2'd0 : active_q + 2'd1;
               end else begin
                  rot_d = rot_q + 1'b1;
               end
            end
         end

         default: begin
            state_d = StManual;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= StManual;
         active_q <= 2'd0;
         target_q <= 2'd0;
         blank_q  <= '0;
         idle_q   <= '0;
         rot_q    <= '0;
      end else begin
         state_q  <= state_d;
         active_q <= active_d;
         target_q <= target_d;
         blank_q  <= blank_d;
         idle_q   <= idle_d;
         rot_q    <= rot_d;
      end
   end

   // ------------------------------------------------------------------
   // Registered display output
   // ------------------------------------------------------------------
   logic [7:0] seg_q, seg_d;
   logic [3:0] an_q, an_d;

   always_comb begin
      seg_d = 8'hFF;
      an_d  = 4'hF;
      if (state_q != StBlank) begin
         case (active_q)
            2'd0: begin
               seg_d = seg_a;
               an_d  = an_a;
            end
            2'd1: begin
               seg_d = seg_b;
               an_d  = an_b;
            end
            default: begin
               seg_d = seg_c;
               an_d  = an_c;
            end
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         seg_q <= 8'hFF;
         an_q  <= 4'hF;
      end else begin
         seg_q <= seg_d;
         an_q  <= an_d;
      end
   end

   assign seg       = seg_q;
   assign an        = an_q;
   assign active    = active_q;
   assign auto_mode = (state_q == StAuto);

endmodule

// File: tb/tb_pattern_arbiter.sv
module tb_pattern_arbiter;

   localparam int unsigned DB   = 4;
   localparam int unsigned BL   = 3;
   localparam int unsigned IDLE = 5;
   localparam int unsigned ROT  = 2;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       btn1 = 1'b0, btn2 = 1'b0, btn3 = 1'b0;
   logic       step_en = 1'b0;
   logic [7:0] seg_a = 8'h11, seg_b = 8'h22, seg_c = 8'h33;
   logic [3:0] an_a = 4'h1, an_b = 4'h2, an_c = 4'h4;
   logic [7:0] seg;
   logic [3:0] an;
   logic [1:0] active;
   logic       auto_mode;

   always #5 CLK = ~CLK;

   pattern_arbiter #(
      .DB_CYCLES   (DB),
      .BLANK_CYCLES(BL),
      .IDLE_STEPS  (IDLE),
      .AUTO_STEPS  (ROT)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .btn1     (btn1),
      .btn2     (btn2),
      .btn3     (btn3),
      .step_en  (step_en),
      .seg_a    (seg_a),
      .seg_b    (seg_b),
      .seg_c    (seg_c),
      .an_a     (an_a),
      .an_b     (an_b),
      .an_c     (an_c),
      .seg      (seg),
      .an       (an),
      .active   (active),
      .auto_mode(auto_mode)
   );

   int total = 0;
   int bad   = 0;
   logic rand_src = 1'b0;

   // Reference model: raw sample history, stability run lengths, pending presses,
   // and the displayed source expressed as a blanking countdown plus an auto flag.
   int m_s1[3], m_s2[3], m_db[3], m_run[3], m_press[3];
   int m_active = 0, m_target = 0, m_blank_left = 0, m_auto = 0, m_idle = 0, m_rot = 0;
   logic [7:0] exp_seg = 8'hFF;
   logic [3:0] exp_an  = 4'hF;

   task automatic model_edge();
      int raw[3];
      int newp[3];
      int any;
      int tgt;
      raw[0] = int'(btn1);
      raw[1] = int'(btn2);
      raw[2] = int'(btn3);
      if (RST) begin
         for (int i = 0; i < 3; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_db[i] = 0; m_run[i] = 0; m_press[i] = 0;
         end
         m_active = 0; m_target = 0; m_blank_left = 0; m_auto = 0; m_idle = 0; m_rot = 0;
         exp_seg = 8'hFF;
         exp_an  = 4'hF;
         return;
      end
      if (m_blank_left > 0) begin
         exp_seg = 8'hFF;
         exp_an  = 4'hF;
      end else if (m_active == 0) begin
         exp_seg = seg_a; exp_an = an_a;
      end else if (m_active == 1) begin
         exp_seg = seg_b; exp_an = an_b;
      end else begin
         exp_seg = seg_c; exp_an = an_c;
      end
      any = m_press[0] | m_press[1] | m_press[2];
      tgt = (m_press[0] != 0) ? 0 : ((m_press[1] != 0) ? 1 : 2);
      if (m_blank_left > 0) begin
         if (any != 0) begin
            m_target = tgt;
            m_blank_left = BL;
         end else begin
            m_blank_left--;
            if (m_blank_left == 0) begin
               m_active = m_target;
               m_idle = 0;
            end
         end
      end else if (any != 0) begin
         m_auto = 0;
         if (tgt != m_active) begin
            m_target = tgt;
            m_blank_left = BL;
         end else begin
            m_idle = 0;
         end
      end else if (step_en) begin
         if (m_auto != 0) begin
            m_rot++;
            if (m_rot == ROT) begin
               m_rot = 0;
               m_active = (m_active + 1) % 3;
            end
         end else begin
            m_idle++;
            if (m_idle == IDLE) begin
               m_auto = 1;
               m_rot = 0;
            end
         end
      end
      for (int i = 0; i < 3; i++) begin
         newp[i] = 0;
         if (m_s2[i] != m_db[i]) begin
            m_run[i]++;
            if (m_run[i] == DB) begin
               m_db[i] = m_s2[i];
               m_run[i] = 0;
               newp[i] = m_db[i];
            end
         end else begin
            m_run[i] = 0;
         end
      end
      for (int i = 0; i < 3; i++) begin
         m_press[i] = newp[i];
         m_s2[i] = m_s1[i];
         m_s1[i] = raw[i];
      end
   endtask

   // Advance one clock: model follows the edge, outputs are then stable for checking.
   task automatic tick();
      @(posedge CLK);
      model_edge();
      #1;
      if (rand_src) begin
         seg_a = 8'($urandom_range(254, 0));
         seg_b = 8'($urandom_range(254, 0));
         seg_c = 8'($urandom_range(254, 0));
         an_a  = 4'($urandom);
         an_b  = 4'($urandom);
         an_c  = 4'($urandom);
      end
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (3) begin
         tick();
         total++;
         if (seg !== 8'hFF || an !== 4'hF || active !== 2'd0 || auto_mode !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold got seg=%h an=%h act=%0d auto=%b want seg=ff an=f act=0 auto=0",
                     seg, an, active, auto_mode);
         end
      end
      RST = 1'b0;
      tick();
      total++;
      if (seg !== 8'h11 || an !== 4'h1 || active !== 2'd0 || auto_mode !== 1'b0) begin
         bad++;
         $display("FAIL reset_release got seg=%h an=%h act=%0d auto=%b want seg=11 an=1 act=0 auto=0",
                  seg, an, active, auto_mode);
      end
      tick();
      total++;
      if ({seg, an, active, auto_mode} !== {exp_seg, exp_an, 2'(m_active), 1'(m_auto)}) begin
         bad++;
         $display("FAIL reset_steady got seg=%h an=%h act=%0d want seg=%h an=%h act=%0d",
                  seg, an, active, exp_seg, exp_an, m_active);
      end
   endtask

   task automatic test_glitch_hold();
      int ff_cnt = 0;
      int switches = 0;
      logic [1:0] prev = active;
      rand_src = 1'b1;
      for (int c = 0; c < 120; c++) begin
         btn2 = (c < 3) ? 1'b1 : ((c < 6) ? 1'b0 : 1'b1);
         tick();
         total++;
         if ({seg, an, active, auto_mode} !== {exp_seg, exp_an, 2'(m_active), 1'(m_auto)}) begin
            bad++;
            $display("FAIL glitch_cyc%0d got seg=%h an=%h act=%0d auto=%b want seg=%h an=%h act=%0d auto=%0d",
                     c, seg, an, active, auto_mode, exp_seg, exp_an, m_active, m_auto);
         end
         if (seg === 8'hFF) ff_cnt++;
         if (active !== prev) switches++;
         prev = active;
      end
      total++;
      if (ff_cnt != 3 || switches != 1 || active !== 2'd1) begin
         bad++;
         $display("FAIL glitch_summary got blank=%0d switches=%0d act=%0d want blank=3 switches=1 act=1",
                  ff_cnt, switches, active);
      end
   endtask

   task automatic test_priority();
      int ff_cnt = 0;
      btn2 = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (c == 15) begin
            btn1 = 1'b1;
            btn3 = 1'b1;
         end
         tick();
         total++;
         if ({seg, an, active, auto_mode} !== {exp_seg, exp_an, 2'(m_active), 1'(m_auto)}) begin
            bad++;
            $display("FAIL priority_cyc%0d got seg=%h an=%h act=%0d want seg=%h an=%h act=%0d",
                     c, seg, an, active, exp_seg, exp_an, m_active);
         end
         if (seg === 8'hFF) ff_cnt++;
      end
      total++;
      if (active !== 2'd0 || ff_cnt != 3) begin
         bad++;
         $display("FAIL priority_final got act=%0d blank=%0d want act=0 blank=3", active, ff_cnt);
      end
   endtask

   task automatic test_retarget();
      int ff_cnt = 0;
      btn1 = 1'b0;
      btn3 = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (c == 10) btn3 = 1'b1;
         if (c == 12) btn2 = 1'b1;
         tick();
         total++;
         if ({seg, an, active, auto_mode} !== {exp_seg, exp_an, 2'(m_active), 1'(m_auto)}
             || active === 2'd2) begin
            bad++;
            $display("FAIL retarget_cyc%0d got seg=%h an=%h act=%0d want seg=%h an=%h act=%0d",
                     c, seg, an, active, exp_seg, exp_an, m_active);
         end
         if (seg === 8'hFF) ff_cnt++;
      end
      total++;
      if (active !== 2'd1 || ff_cnt != 5) begin
         bad++;
         $display("FAIL retarget_final got act=%0d blank=%0d want act=1 blank=5", active, ff_cnt);
      end
   endtask

   task automatic test_auto_rotate();
      int gap = 2;
      int ff_cnt = 0;
      int rotations = 0;
      logic [1:0] prev;
      logic done = 1'b0;
      btn2 = 1'b0;
      btn3 = 1'b0;
      repeat (10) tick();
      prev = active;
      for (int c = 0; c < 400 && !done; c++) begin
         step_en = (gap == 0);
         if (gap == 0) gap = int'($urandom_range(3, 1));
         else gap--;
         tick();
         step_en = 1'b0;
         total++;
         if ({seg, an, active, auto_mode} !== {exp_seg, exp_an, 2'(m_active), 1'(m_auto)}) begin
            bad++;
            $display("FAIL auto_cyc%0d got seg=%h an=%h act=%0d auto=%b want seg=%h an=%h act=%0d auto=%0d",
                     c, seg, an, active, auto_mode, exp_seg, exp_an, m_active, m_auto);
         end
         if (seg === 8'hFF) ff_cnt++;
         if (active !== prev) begin
            rotations++;
            total++;
            if (active !== ((prev == 2'd2) ? 2'd0 : prev + 2'd1) || auto_mode !== 1'b1) begin
               bad++;
               $display("FAIL auto_step got act=%0d auto=%b after act=%0d", active, auto_mode, prev);
            end
         end
         prev = active;
         if (rotations >= 3 && m_active == 2 && m_rot == 0) done = 1'b1;
      end
      total++;
      if (!done || auto_mode !== 1'b1 || active !== 2'd2 || ff_cnt != 0) begin
         bad++;
         $display("FAIL auto_final got done=%b auto=%b act=%0d blank=%0d want done=1 auto=1 act=2 blank=0",
                  done, auto_mode, active, ff_cnt);
      end
   endtask

   task automatic test_auto_exit();
      int ff_cnt = 0;
      btn3 = 1'b1;
      for (int c = 0; c < 25; c++) begin
         tick();
         total++;
         if ({seg, an, active, auto_mode} !== {exp_seg, exp_an, 2'(m_active), 1'(m_auto)}) begin
            bad++;
            $display("FAIL autoexit_cyc%0d got seg=%h act=%0d auto=%b want seg=%h act=%0d auto=%0d",
                     c, seg, active, auto_mode, exp_seg, m_active, m_auto);
         end
         if (seg === 8'hFF) ff_cnt++;
      end
      total++;
      if (auto_mode !== 1'b0 || active !== 2'd2 || ff_cnt != 0) begin
         bad++;
         $display("FAIL autoexit_final got auto=%b act=%0d blank=%0d want auto=0 act=2 blank=0",
                  auto_mode, active, ff_cnt);
      end
   endtask

   task automatic test_reset_mid_blank();
      btn3 = 1'b0;
      repeat (8) tick();
      btn1 = 1'b1;
      for (int c = 0; c < 30 && m_blank_left == 0; c++) begin
         tick();
         total++;
         if ({seg, an, active, auto_mode} !== {exp_seg, exp_an, 2'(m_active), 1'(m_auto)}) begin
            bad++;
            $display("FAIL midblank_cyc%0d got seg=%h act=%0d want seg=%h act=%0d",
                     c, seg, active, exp_seg, m_active);
         end
      end
      total++;
      if (m_blank_left == 0) begin
         bad++;
         $display("FAIL midblank_timeout got no blank want blank within 30 cycles");
      end
      tick();
      RST = 1'b1;
      btn1 = 1'b0;
      tick();
      total++;
      if (seg !== 8'hFF || an !== 4'hF || active !== 2'd0 || auto_mode !== 1'b0) begin
         bad++;
         $display("FAIL midblank_reset got seg=%h an=%h act=%0d auto=%b want seg=ff an=f act=0 auto=0",
                  seg, an, active, auto_mode);
      end
      RST = 1'b0;
      for (int c = 0; c < 12; c++) begin
         tick();
         total++;
         if ({seg, an, active, auto_mode} !== {exp_seg, exp_an, 2'(m_active), 1'(m_auto)}
             || active !== 2'd0) begin
            bad++;
            $display("FAIL postreset_cyc%0d got seg=%h an=%h act=%0d want seg=%h an=%h act=0",
                     c, seg, an, active, exp_seg, exp_an);
         end
      end
   endtask

   initial begin
      test_reset();
      test_glitch_hold();
      test_priority();
      test_retarget();
      test_auto_rotate();
      test_auto_exit();
      test_reset_mid_blank();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pattern_arbiter.md
# pattern_arbiter

Sequencer that owns the shared seven-segment display and decides which of the three pattern generators drives it. It debounces the three select buttons, applies fixed priority to simultaneous presses, and holds the chosen pattern after release. It inserts a blanking gap on every source switch and falls into an auto-rotate demo mode after a period of inactivity. It sits between the pattern generators and the `seg`/`an` pins, replacing the level-sensitive button mux.

## Interface
- `DB_CYCLES`, 500000: consecutive stable samples required to accept a button level change (5 ms at 100 MHz); ≥2.
- `BLANK_CYCLES`, 1000000: display-blank duration on a source switch, in CLK cycles; ≥1.
- `IDLE_STEPS`, 64: `step_en` pulses with no press before entering auto mode; ≥1.
- `AUTO_STEPS`, 16: `step_en` pulses per pattern while in auto mode; ≥1.
- `CLK` in 1: system clock; the only clock.
- `RST` in 1: reset, synchronous, active-high.
- `btn1`, `btn2`, `btn3` in 1 each: raw, asynchronous, bouncing buttons; select pattern 0/1/2.
- `step_en` in 1: one-CLK-cycle strobe at the selected pattern speed, from the speed mux.
- `seg_a`, `seg_b`, `seg_c` in 8 each: segment buses of patterns 0/1/2, active-low.
- `an_a`, `an_b`, `an_c` in 4 each: anode buses of patterns 0/1/2, active-low.
- `seg` out 8: display segments; `an` out 4: display anodes.
- `active` out 2: currently displayed pattern index, 0..2; never 3.
- `auto_mode` out 1: high while in AUTO.

## Operation
- Input sync: each button passes through a 2-flop synchronizer, then the debouncer.
- Debounce: per button, a counter increments every cycle the synced level ≠ debounced level and clears on a match. The debounced level flips on the cycle the counter reaches `DB_CYCLES`. A press is the 1-cycle rising edge of the debounced level. Releases generate nothing.
- Priority: on same-cycle presses, btn1 > btn2 > btn3; lower-priority presses are dropped.
- FSM states:
  - MANUAL: idle counter counts `step_en` pulses and saturates at `IDLE_STEPS`.
    - Reaching `IDLE_STEPS` → AUTO, with the rotate counter cleared.
    - Press with target ≠ `active` → BLANK, with target latched and the blank counter cleared.
    - Press with target = `active` → stay in MANUAL and clear the idle counter.
  - BLANK: blank counter counts CLK cycles.
    - After `BLANK_CYCLES` cycles in BLANK: `active` ← target, state → MANUAL, idle counter cleared.
    - A new press during BLANK re-latches the target and restarts the blank counter.
    - `step_en` is ignored.
  - AUTO: rotate counter counts `step_en` pulses.
    - At `AUTO_STEPS`, `active` advances 0→1→2→0, the counter clears, and there is no blanking.
    - Any press → clear `auto_mode`. If target ≠ `active`, go to BLANK; otherwise go to MANUAL with the idle counter cleared.
- Output: `seg`/`an` are registered.
  - In BLANK: `seg`=8'hFF, `an`=4'hF.
  - Otherwise: the buses of the source selected by `active`.
- Counter widths are `$clog2(param+1)`. No counter wraps; each either saturates or is explicitly cleared.

## Timing
- Reset values: `seg`=8'hFF, `an`=4'hF, `active`=0, `auto_mode`=0, state MANUAL. All counters, synchronizers and debounced levels are 0.
- Reset mid-BLANK or mid-AUTO returns to these values on the next edge; any pending target is discarded.
- Press latency, counted from the first edge sampling raw high (edge 1):
  - Debounced high after edge DB_CYCLES+2.
  - FSM in BLANK after edge DB_CYCLES+3.
  - `seg`=FF after edge DB_CYCLES+4.
- Switch: `active` changes on the edge ending the `BLANK_CYCLES`-th BLANK cycle. `seg`/`an` show the new source one edge later.
- Steady-state data latency from `seg_x`/`an_x` to `seg`/`an`: 1 cycle.
- `auto_mode` rises on the edge that accepts the `IDLE_STEPS`-th `step_en`. It falls on the edge that accepts the exiting press.
- A press and a `step_en` in the same cycle: the press wins, and the `step_en` is not counted.
- A button held indefinitely produces exactly one press.

## Test plan
Bench parameters: `DB_CYCLES`=4, `BLANK_CYCLES`=3, `IDLE_STEPS`=5, `AUTO_STEPS`=2.
- Reset, then drive the sources with 8'h11/8'h22/8'h33 and no buttons → `seg`=8'h11 and `active`=0 one cycle after reset release; `seg`=8'hFF, `an`=4'hF while `RST` is high.
- `btn2` toggles high for 3 cycles, then stays high continuously → no press from the glitch. Exactly one switch to `active`=1, with `seg`=FF for exactly 3 cycles, then 8'h22. Holding the button 100 cycles causes no further switch.
- `btn1` and `btn3` rise in the same cycle while `active`=1 → target 0 only; final `seg`=8'h11.
- Press `btn3`, then press `btn2` two cycles into BLANK → blank extends to 3 cycles after the second press; final `active`=1, never 2.
- No presses, with 5 `step_en` pulses → `auto_mode`=1. Then every 2 `step_en` pulses `active` steps 0→1→2→0 with no FF gap.
- In AUTO with `active`=2, press `btn3` → `auto_mode` clears and `active` stays 2 with no blank. Pulsing `RST` while in BLANK returns all outputs to their reset values.
